// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - producer, decode and register-file write bundle for regfile_wb_queue
// Fwd* signals exist only when WBQ_BYPASS_EN is defined.
interface regfile_wb_queue_if #(
  parameter int PTRW = 2
);
  logic            MemValid;
  logic [4:0]      MemReg;
  logic [31:0]     MemData;
  logic            MemReady;
  logic            AluValid;
  logic [4:0]      AluReg;
  logic [31:0]     AluData;
  logic            AluReady;
  logic [4:0]      ReadRegister1;
  logic [4:0]      ReadRegister2;
  logic            Pend1;
  logic            Pend2;
  logic            RegWrite;
  logic [4:0]      WriteRegister;
  logic [31:0]     WriteData;
  logic [PTRW:0]   Count;
`ifdef WBQ_BYPASS_EN
  logic            Fwd1Valid;
  logic [31:0]     Fwd1Data;
  logic            Fwd2Valid;
  logic [31:0]     Fwd2Data;
`endif

  modport master (
    output MemValid, MemReg, MemData,
    input  MemReady,
    output AluValid, AluReg, AluData,
    input  AluReady,
    output ReadRegister1, ReadRegister2,
    input  Pend1, Pend2,
    input  RegWrite, WriteRegister, WriteData, Count
`ifdef WBQ_BYPASS_EN
    , input Fwd1Valid, Fwd1Data, Fwd2Valid, Fwd2Data
`endif
  );

  modport slave (
    input  MemValid, MemReg, MemData,
    output MemReady,
    input  AluValid, AluReg, AluData,
    output AluReady,
    input  ReadRegister1, ReadRegister2,
    output Pend1, Pend2,
    output RegWrite, WriteRegister, WriteData, Count
`ifdef WBQ_BYPASS_EN
    , output Fwd1Valid, Fwd1Data, Fwd2Valid, Fwd2Data
`endif
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back FIFO feeding the 32x32 register file write port
// Optional forwarding outputs are enabled by defining WBQ_BYPASS_EN.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input logic              Clk,
  input logic              Reset,
  regfile_wb_queue_if.slave bus
);

  localparam logic [PTRW:0] DEPTH_C = (PTRW+1)'(DEPTH);

  logic [4:0]       ent_reg  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW-1:0]  alu_slot;
  logic [PTRW:0]    count;
  logic [PTRW:0]    count_after_mem;
  logic             mem_push;
  logic             alu_push;
  logic             pop;

  // Readiness looks only at the current occupancy; a same-edge pop earns no credit.
  assign bus.MemReady    = count < DEPTH_C;
  assign mem_push        = bus.MemValid && bus.MemReady && (bus.MemReg != 5'd0);
  assign count_after_mem = count + (PTRW+1)'(mem_push);
  assign bus.AluReady    = count_after_mem < DEPTH_C;
  assign alu_push        = bus.AluValid && bus.AluReady && (bus.AluReg != 5'd0);
  assign alu_slot        = tail + PTRW'(mem_push);
  assign pop             = count != '0;
  assign bus.Count       = count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      ent_vld           <= '0;
      bus.RegWrite      <= 1'b0;
      bus.WriteRegister <= 5'd0;
      bus.WriteData     <= 32'd0;
    end else begin
      if (pop) begin
        ent_vld[head]     <= 1'b0;
        head              <= head + PTRW'(1);
        bus.RegWrite      <= 1'b1;
        bus.WriteRegister <= ent_reg[head];
        bus.WriteData     <= ent_data[head];
      end else begin
        bus.RegWrite      <= 1'b0;
      end
      // Memory result is older than a same-cycle ALU result, so it takes the lower slot.
      if (mem_push) begin
        ent_vld[tail]  <= 1'b1;
        ent_reg[tail]  <= bus.MemReg;
        ent_data[tail] <= bus.MemData;
      end
      if (alu_push) begin
        ent_vld[alu_slot]  <= 1'b1;
        ent_reg[alu_slot]  <= bus.AluReg;
        ent_data[alu_slot] <= bus.AluData;
      end
      tail  <= tail + PTRW'(mem_push) + PTRW'(alu_push);
      count <= count + (PTRW+1)'(mem_push) + (PTRW+1)'(alu_push) - (PTRW+1)'(pop);
    end
  end

  logic [PTRW-1:0] idx;
  logic            pend1;
  logic            pend2;
`ifdef WBQ_BYPASS_EN
  logic [31:0]     fwd1_data;
  logic [31:0]     fwd2_data;
`endif

  // Walk oldest to youngest (output stage, then head..tail) so the last hit is the youngest write.
  always_comb begin
    idx   = head;
    pend1 = 1'b0;
    pend2 = 1'b0;
`ifdef WBQ_BYPASS_EN
    fwd1_data = 32'd0;
    fwd2_data = 32'd0;
`endif
    if (bus.RegWrite && (bus.WriteRegister == bus.ReadRegister1)) begin
      pend1 = 1'b1;
`ifdef WBQ_BYPASS_EN
      fwd1_data = bus.WriteData;
`endif
    end
    if (bus.RegWrite && (bus.WriteRegister == bus.ReadRegister2)) begin
      pend2 = 1'b1;
`ifdef WBQ_BYPASS_EN
      fwd2_data = bus.WriteData;
`endif
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTRW'(i);
      if (ent_vld[idx] && (ent_reg[idx] == bus.ReadRegister1)) begin
        pend1 = 1'b1;
`ifdef WBQ_BYPASS_EN
        fwd1_data = ent_data[idx];
`endif
      end
      if (ent_vld[idx] && (ent_reg[idx] == bus.ReadRegister2)) begin
        pend2 = 1'b1;
`ifdef WBQ_BYPASS_EN
        fwd2_data = ent_data[idx];
`endif
      end
    end
    if (bus.ReadRegister1 == 5'd0) pend1 = 1'b0;
    if (bus.ReadRegister2 == 5'd0) pend2 = 1'b0;
  end

  assign bus.Pend1 = pend1;
  assign bus.Pend2 = pend2;
`ifdef WBQ_BYPASS_EN
  assign bus.Fwd1Valid = pend1;
  assign bus.Fwd1Data  = fwd1_data;
  assign bus.Fwd2Valid = pend2;
  assign bus.Fwd2Data  = fwd2_data;
`endif

endmodule
